// File: rtl/control_unit_pipe.sv
// EX-stage control unit: registered MIPS R/I-type decode with multiply stall,
// GPIO read handshake with timeout, taken-bne flush and illegal-instruction pulse.
module control_unit_pipe #(
    parameter int MULT_LATENCY = 4,
    parameter int GPIO_TIMEOUT = 16,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic [31:0] instr,
    input  logic        zero_EX,
    input  logic        gpio_in_ready,
    output logic [3:0]  alu_op,
    output logic [4:0]  shamt_EX,
    output logic [1:0]  regsel_EX,
    output logic        enhilo_EX,
    output logic        regwrite_EX,
    output logic        rdrt_EX,
    output logic [1:0]  alu_src_EX,
    output logic [1:0]  pc_src_EX,
    output logic        stall_FETCH,
    output logic        gpio_out_en,
    output logic        gpio_timeout,
    output logic        illegal_EX
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MULT_WAIT,
        S_GPIO_WAIT,
        S_FLUSH
    } state_t;

    typedef struct packed {
        logic [3:0] alu_op;
        logic [4:0] shamt;
        logic [1:0] regsel;
        logic       enhilo;
        logic       regwrite;
        logic       rdrt;
        logic [1:0] alu_src;
        logic [1:0] pc_src;
        logic       gpio_out_en;
        logic       gpio_timeout;
        logic       illegal;
    } ctl_t;

    typedef struct packed {
        ctl_t ctl;
        logic is_mult;
        logic is_gpio_rd;
        logic is_bne;
    } dec_t;

    localparam logic [7:0] LP_MULT_END  = 8'(MULT_LATENCY - 1);
    localparam logic [7:0] LP_GPIO_END  = 8'(GPIO_TIMEOUT);
    localparam logic [7:0] LP_FLUSH_END = 8'(FLUSH_CYCLES);

    function automatic dec_t decode(input logic [31:0] ins);
        dec_t       d;
        logic [5:0] op;
        logic [5:0] fn;
        logic [4:0] sh;
        d  = '0;
        op = ins[31:26];
        fn = ins[5:0];
        sh = ins[10:6];
        // The all-zero word is the canonical NOP, not an sll
        if (ins != 32'h0) begin
            case (op)
                6'b000000: begin
                    d.ctl.regwrite = 1'b1;
                    case (fn)
                        6'b100000, 6'b100001: d.ctl.alu_op = 4'b0100;
                        6'b100010, 6'b100011: d.ctl.alu_op = 4'b0101;
                        6'b100100:            d.ctl.alu_op = 4'b0000;
                        6'b100101:            d.ctl.alu_op = 4'b0001;
                        6'b100110:            d.ctl.alu_op = 4'b0011;
                        6'b100111:            d.ctl.alu_op = 4'b0010;
                        6'b101010:            d.ctl.alu_op = 4'b1100;
                        6'b101011:            d.ctl.alu_op = 4'b1101;
                        6'b000000: begin
                            d.ctl.alu_op = 4'b1000;
                            d.ctl.shamt  = sh;
                        end
                        // Zero-shift srl/sra are repurposed as GPIO write/read
                        6'b000010: begin
                            if (sh != 5'd0) begin
                                d.ctl.alu_op = 4'b1001;
                                d.ctl.shamt  = sh;
                            end else begin
                                d.ctl.regwrite    = 1'b0;
                                d.ctl.gpio_out_en = 1'b1;
                            end
                        end
                        6'b000011: begin
                            if (sh != 5'd0) begin
                                d.ctl.alu_op = 4'b1010;
                                d.ctl.shamt  = sh;
                            end else begin
                                d.ctl.regwrite = 1'b0;
                                d.is_gpio_rd   = 1'b1;
                            end
                        end
                        6'b010000: d.ctl.regsel = 2'd1;
                        6'b010010: d.ctl.regsel = 2'd2;
                        6'b011000, 6'b011001: begin
                            d.ctl.alu_op   = fn[0] ? 4'b0111 : 4'b0110;
                            d.ctl.enhilo   = 1'b1;
                            d.ctl.regwrite = 1'b0;
                            d.is_mult      = 1'b1;
                        end
                        default: begin
                            d.ctl.regwrite = 1'b0;
                            d.ctl.illegal  = 1'b1;
                        end
                    endcase
                end
                6'b001000, 6'b001001: begin
                    d.ctl.alu_op   = 4'b0100;
                    d.ctl.alu_src  = 2'd1;
                    d.ctl.rdrt     = 1'b1;
                    d.ctl.regwrite = 1'b1;
                end
                6'b001101: begin
                    d.ctl.alu_op   = 4'b0001;
                    d.ctl.alu_src  = 2'd2;
                    d.ctl.rdrt     = 1'b1;
                    d.ctl.regwrite = 1'b1;
                end
                6'b001111: begin
                    d.ctl.alu_op   = 4'b1000;
                    d.ctl.shamt    = 5'd16;
                    d.ctl.alu_src  = 2'd2;
                    d.ctl.rdrt     = 1'b1;
                    d.ctl.regwrite = 1'b1;
                end
                6'b000101: begin
                    d.ctl.alu_op = 4'b0101;
                    d.is_bne     = 1'b1;
                end
                default: d.ctl.illegal = 1'b1;
            endcase
        end
        return d;
    endfunction

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_nxt;
    dec_t       w_dec_p0;
    ctl_t       w_ctl_p0;
    logic       w_is_bne_p0;
    logic       w_taken;
    ctl_t       r_ctl_p1;
    logic       r_stall_p1;
    logic       r_is_bne_p1;

    // Stage p0: decode and next-state selection
    always_comb begin
        w_dec_p0    = decode(instr);
        w_taken     = r_is_bne_p1 && !zero_EX;
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ctl_p0    = '0;
        w_is_bne_p0 = 1'b0;
        case (r_state)
            S_IDLE: begin
                // A taken bne in EX squashes whatever is offered this cycle
                if (w_taken) begin
                    w_state_nxt     = S_FLUSH;
                    w_cnt_nxt       = 8'd1;
                    w_ctl_p0.pc_src = 2'd1;
                end else if (valid_in) begin
                    w_ctl_p0    = w_dec_p0.ctl;
                    w_is_bne_p0 = w_dec_p0.is_bne;
                    if (w_dec_p0.is_gpio_rd) begin
                        w_state_nxt = S_GPIO_WAIT;
                        w_cnt_nxt   = 8'd1;
                    end else if (w_dec_p0.is_mult && (MULT_LATENCY > 1)) begin
                        w_state_nxt = S_MULT_WAIT;
                        w_cnt_nxt   = 8'd1;
                    end
                end
            end
            S_MULT_WAIT: begin
                if (r_cnt == LP_MULT_END) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            S_GPIO_WAIT: begin
                if (gpio_in_ready) begin
                    w_ctl_p0.regwrite = 1'b1;
                    w_ctl_p0.regsel   = 2'd3;
                    w_state_nxt       = S_IDLE;
                end else if (r_cnt == LP_GPIO_END) begin
                    w_ctl_p0.gpio_timeout = 1'b1;
                    w_state_nxt           = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            S_FLUSH: begin
                if (r_cnt == LP_FLUSH_END) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt       = r_cnt + 8'd1;
                    w_ctl_p0.pc_src = 2'd1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Stage p1: EX control register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 8'd0;
            r_ctl_p1    <= '0;
            r_stall_p1  <= 1'b0;
            r_is_bne_p1 <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_ctl_p1    <= w_ctl_p0;
            r_stall_p1  <= (w_state_nxt != S_IDLE);
            r_is_bne_p1 <= w_is_bne_p0;
        end
    end

    assign alu_op       = r_ctl_p1.alu_op;
    assign shamt_EX     = r_ctl_p1.shamt;
    assign regsel_EX    = r_ctl_p1.regsel;
    assign enhilo_EX    = r_ctl_p1.enhilo;
    assign regwrite_EX  = r_ctl_p1.regwrite;
    assign rdrt_EX      = r_ctl_p1.rdrt;
    assign alu_src_EX   = r_ctl_p1.alu_src;
    assign pc_src_EX    = r_ctl_p1.pc_src;
    assign stall_FETCH  = r_stall_p1;
    assign gpio_out_en  = r_ctl_p1.gpio_out_en;
    assign gpio_timeout = r_ctl_p1.gpio_timeout;
    assign illegal_EX   = r_ctl_p1.illegal;

endmodule
